wallace_reduce_pipe: RTL and testbench
======================================

// Module: wallace_reduce_pipe
// PURPOSE
//  Pipelined Wallace-tree front end of the multiplier: forms the W x W partial-product
//  array and reduces it with 3:2 carry-save rows to two 2W-bit rows (sum, carry).
//  Sits directly upstream of the Kogge-Stone final adder, which forms the product
//  as (row_s + row_c) mod 2^(2W). Valid/ready on both sides; one result per cycle.
// PARAMETERS
//  W      4   operand width in bits (>= 2)
//  TAG_W  4   sideband tag width, carried unmodified alongside each operand pair
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand pair on a/b/in_tag is valid
//  in_ready   out  1      block accepts a pair this cycle
//  a          in   W      multiplicand
//  b          in   W      multiplier
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      row_s/row_c/out_tag are valid
//  out_ready  in   1      final adder consumes the rows this cycle
//  row_s      out  2W     carry-save sum row
//  row_c      out  2W     carry-save carry row, already shifted to its weight
//  out_tag    out  TAG_W  tag of the pair that produced the rows
// BEHAVIOUR
//  - Stage 1 (PP): registers W partial-product rows pp[i] = (a & {W{b[i]}}) << i, 2W wide.
//  - Stage 2 (RED): combinational 3:2 reduction of the stage-1 rows to two rows; registered.
//  - Latency: pair accepted in cycle n appears on outputs in cycle n+2 if not stalled.
//  - Transfer occurs when valid && ready on a side. Per stage: advance = !v_next || ready_next;
//    in_ready = !v1 || advance1 (combinational from out_ready; no skid buffer).
//  - A stalled output holds row_s/row_c/out_tag/out_valid stable until out_ready.
//  - Both stages full + out_ready low: in_ready = 0; nothing overwritten or dropped.
//  - Simultaneous accept and emit when full and out_ready = 1: full throughput, no bubble.
//  - Arithmetic: all rows 2W bits; carries out of bit 2W-1 discarded (mod 2^(2W)).
//  - Reset (any time, including mid-operation): v1 = v2 = 0, out_valid = 0, row_s = 0,
//    row_c = 0, out_tag = 0; in-flight pairs discarded; in_ready = 1 the cycle after release.
//  - Datapath registers load only on stage advance with valid input (no toggling when idle).
// CONFIGURATION
//  WALLACE_SIGNED_EN defined: operands are two's complement (Baugh-Wooley):
//   pp[i][W-1] inverted for i < W-1; pp[W-1][j] inverted for j < W-1; constant 1 added at
//   columns W and 2W-1 in stage 2; (row_s + row_c) mod 2^(2W) = signed product.
//  Undefined: operands unsigned, no inversions, no constants.
// STRUCTURE
//  - wallace_pkg: W default, TAG_W default, function csa_layers(n) giving reduction depth,
//    typedef of the 2W-bit row type.
//  - Sub-module csa_row: N-bit row of full adders (3 rows in, sum row + carry row <<1 out);
//    instantiated per 3:2 group in the stage-2 reduction.
// TESTING (W = 4, TAG_W = 4; check (row_s + row_c) mod 256)
//  - a=15, b=15, tag=3 -> 225, out_tag=3, exactly 2 cycles after acceptance.
//  - Stream 16 pairs, out_ready=1 -> 16 results in order, one per cycle, in_ready never 0.
//  - out_ready=0 for 4 cycles with in_valid held -> in_ready drops after 2 accepts,
//    outputs stable during stall, no loss or duplication on release.
//  - Unsigned build: a=0, b=9 -> row_s = row_c = 0; a=12, b=5 -> 60.
//  - WALLACE_SIGNED_EN: a=4'b1000 (-8), b=7 -> 8'hC8 (-56); a=-1, b=-1 -> 1.
//  - rst asserted with both stages full -> out_valid=0 and rows 0 immediately
//    (asynchronous); no stale result after release.

Source files
------------

// File: rtl/wallace_pkg.sv
// Shared defaults and helpers for the Wallace-tree front end.
// Reduction depth helpers are evaluated at elaboration time to size the CSA tree.
package wallace_pkg;

    localparam int W_DEF     = 4;
    localparam int TAG_W_DEF = 4;

    typedef logic [2*W_DEF-1:0] row_t;

    // Rows left after 'layers' levels of 3:2 reduction, starting from n rows.
    function automatic int rows_after(input int n, input int layers);
        int r;
        r = n;
        for (int l = 0; l < layers; l++) begin
            if (r > 2) begin
                r = r - (r / 3);
            end
        end
        return r;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int csa_layers(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - (r / 3);
            l = l + 1;
        end
        return l;
    endfunction

endpackage

// File: rtl/wallace_reduce_pipe_csa_row.sv
// csa_row: N-bit row of full adders. Three rows in, a sum row and a carry row
// already shifted to its weight out; the carry out of the top bit is dropped.
module csa_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    input  logic [N-1:0] z_i,
    output logic [N-1:0] sum_o,
    output logic [N-1:0] carry_o
);

    logic [N-1:0] maj;

    assign sum_o   = x_i ^ y_i ^ z_i;
    assign maj     = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
    assign carry_o = {maj[N-2:0], 1'b0};

endmodule

// File: rtl/wallace_reduce_pipe.sv
// wallace_reduce_pipe: two-stage partial-product + carry-save reduction pipeline.
// Stage 1 registers the partial-product array, stage 2 registers the two reduced rows.
// Build option: define WALLACE_SIGNED_EN for two's complement (Baugh-Wooley) operands.
module wallace_reduce_pipe
    import wallace_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*W-1:0]     row_s,
    output logic [2*W-1:0]     row_c,
    output logic [TAG_W-1:0]   out_tag
);

`ifdef WALLACE_SIGNED_EN
    // The Baugh-Wooley correction constant rides along as one extra row.
    localparam int N_ROWS = W + 1;
    localparam logic [2*W-1:0] BW_CONST = ((2*W)'(1) << W) | ((2*W)'(1) << (2*W-1));
`else
    localparam int N_ROWS = W;
`endif
    localparam int LAYERS = csa_layers(N_ROWS);

    logic [W-1:0][2*W-1:0] pp_d;
    logic [W-1:0][2*W-1:0] pp_q;
    logic [TAG_W-1:0]      tag1_q;
    logic                  v1_q;

    logic [2*W-1:0]        row_s_d;
    logic [2*W-1:0]        row_c_d;
    logic [2*W-1:0]        row_s_q;
    logic [2*W-1:0]        row_c_q;
    logic [TAG_W-1:0]      tag2_q;
    logic                  v2_q;

    logic                  adv2;

    // Stage 2 drains when empty or when the final adder takes the rows; stage 1 follows it.
    assign adv2     = !v2_q || out_ready;
    assign in_ready = !v1_q || adv2;

    // Partial-product array, with sign-bit inversions for the signed build.
    always_comb begin
        pp_d = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
`ifdef WALLACE_SIGNED_EN
                pp_d[i][i+j] = (a[j] & b[i]) ^ ((j == W-1) != (i == W-1));
`else
                pp_d[i][i+j] = a[j] & b[i];
`endif
            end
        end
    end

    // Stage 1 valid: refilled whenever the stage can accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
        end else if (in_ready) begin
            v1_q <= in_valid;
        end
    end

    // Stage 1 data: loads only on an accepted pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pp_q   <= '0;
            tag1_q <= '0;
        end else if (in_ready && in_valid) begin
            pp_q   <= pp_d;
            tag1_q <= in_tag;
        end
    end

    // Carry-save tree: lvl[l] holds the rows entering reduction level l.
    logic [2*W-1:0] lvl [0:LAYERS][0:N_ROWS-1];

    genvar gi, gj, gk;
    generate
        for (gi = 0; gi < W; gi++) begin : g_lvl0
            assign lvl[0][gi] = pp_q[gi];
        end
`ifdef WALLACE_SIGNED_EN
        assign lvl[0][W] = BW_CONST;
`endif
        for (gi = 0; gi < LAYERS; gi++) begin : g_layer
            localparam int N_IN  = rows_after(N_ROWS, gi);
            localparam int N_GRP = N_IN / 3;
            localparam int N_OUT = N_IN - N_GRP;
            for (gj = 0; gj < N_GRP; gj++) begin : g_grp
                csa_row #(.N(2*W)) u_csa (
                    .x_i     (lvl[gi][3*gj]),
                    .y_i     (lvl[gi][3*gj+1]),
                    .z_i     (lvl[gi][3*gj+2]),
                    .sum_o   (lvl[gi+1][2*gj]),
                    .carry_o (lvl[gi+1][2*gj+1])
                );
            end
            for (gk = 2*N_GRP; gk < N_ROWS; gk++) begin : g_pass
                if (gk < N_OUT) begin : g_keep
                    // Rows left over from the grouping move down unchanged.
                    assign lvl[gi+1][gk] = lvl[gi][gk+N_GRP];
                end else begin : g_zero
                    assign lvl[gi+1][gk] = '0;
                end
            end
        end
    endgenerate

    assign row_s_d = lvl[LAYERS][0];
    assign row_c_d = lvl[LAYERS][1];

    // Stage 2 valid: takes stage 1's valid whenever it advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
        end else if (adv2) begin
            v2_q <= v1_q;
        end
    end

    // Stage 2 data: loads only when advancing with a valid stage-1 entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s_q <= '0;
            row_c_q <= '0;
            tag2_q  <= '0;
        end else if (adv2 && v1_q) begin
            row_s_q <= row_s_d;
            row_c_q <= row_c_d;
            tag2_q  <= tag1_q;
        end
    end

    assign out_valid = v2_q;
    assign row_s     = row_s_q;
    assign row_c     = row_c_q;
    assign out_tag   = tag2_q;

endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Self-checking bench for wallace_reduce_pipe (W=4, TAG_W=4).
// Expected products come from plain integer multiplication of the accepted operands.
module tb_wallace_reduce_pipe;

    localparam int W     = 4;
    localparam int TAG_W = 4;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*W-1:0]     row_s;
    logic [2*W-1:0]     row_c;
    logic [TAG_W-1:0]   out_tag;

    wallace_reduce_pipe #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_s     (row_s),
        .row_c     (row_c),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0]   prod;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    int   pops;
    bit   rand_ready;
    bit   stream_chk;

    bit               have_prev;
    logic [2*W-1:0]   prev_s;
    logic [2*W-1:0]   prev_c;
    logic [TAG_W-1:0] prev_tag;

    // Reference product of one operand pair, modulo 2^(2W).
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        sx = int'(x);
        sy = int'(y);
`ifdef WALLACE_SIGNED_EN
        if (x[W-1]) sx = sx - (1 << W);
        if (y[W-1]) sy = sy - (1 << W);
`endif
        return (2*W)'(sx * sy);
    endfunction

    function automatic logic [2*W-1:0] dut_sum();
        return row_s + row_c;
    endfunction

    // Scoreboard: accepts go in, emitted rows are checked against the oldest entry.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                tests++;
                if (!out_valid || row_s != prev_s || row_c != prev_c || out_tag != prev_tag) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b s=%h c=%h tag=%h, required v=1 s=%h c=%h tag=%h",
                             out_valid, row_s, row_c, out_tag, prev_s, prev_c, prev_tag);
                end
            end
            if (out_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: got sum=%h tag=%h, required no output", dut_sum(), out_tag);
                end else begin
                    if (dut_sum() != exp_q[0].prod || out_tag != exp_q[0].tag) begin
                        fails++;
                        $display("FAIL result: got sum=%h tag=%h, required sum=%h tag=%h",
                                 dut_sum(), out_tag, exp_q[0].prod, exp_q[0].tag);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
            have_prev = out_valid && !out_ready;
            prev_s    = row_s;
            prev_c    = row_c;
            prev_tag  = out_tag;
            if (in_valid && in_ready) begin
                exp_t e;
                e.prod = ref_prod(a, b);
                e.tag  = in_tag;
                exp_q.push_back(e);
            end
        end
    end

    // Random backpressure source for the mixed-traffic phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Present one pair (called at posedge+1) and hold it until accepted.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [TAG_W-1:0] t);
        bit acc;
        acc      = 1'b0;
        a        = x;
        b        = y;
        in_tag   = t;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            if (stream_chk && !in_ready) begin
                tests++;
                fails++;
                $display("FAIL stream_in_ready: got 0, required 1");
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept, required accept within 200 cycles");
        end
    endtask

    // Single pair into an empty pipe; checks latency and the literal product.
    task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic [TAG_W-1:0] t,
                           input logic [2*W-1:0] req, input bit chk_zero);
        bit seen;
        seen      = 1'b0;
        out_ready = 1'b1;
        a         = x;
        b         = y;
        in_tag    = t;
        in_valid  = 1'b1;
        @(negedge clk);
        check("accept_empty", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check("latency", k, 2);
                check("literal_prod", 32'(dut_sum()), 32'(req));
                check("literal_tag", 32'(out_tag), 32'(t));
                if (chk_zero) begin
                    check("zero_row_s", 32'(row_s), 0);
                    check("zero_row_c", 32'(row_c), 0);
                end
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL latency_timeout: got no out_valid, required out_valid 2 cycles after accept");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int acc;
        tests      = 0;
        fails      = 0;
        pops       = 0;
        rand_ready = 1'b0;
        stream_chk = 1'b0;
        have_prev  = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        in_tag     = '0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_row_s", 32'(row_s), 0);
        check("rst_row_c", 32'(row_c), 0);
        check("rst_out_tag", 32'(out_tag), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        // Hand-computed literals
`ifdef WALLACE_SIGNED_EN
        run_one(4'b1000, 4'd7, 4'd5, 8'hC8, 1'b0);
        run_one(4'hF, 4'hF, 4'd6, 8'h01, 1'b0);
`else
        run_one(4'd15, 4'd15, 4'd3, 8'd225, 1'b0);
        run_one(4'd0, 4'd9, 4'd1, 8'd0, 1'b1);
        run_one(4'd12, 4'd5, 4'd2, 8'd60, 1'b0);
`endif

        // Back-to-back stream of 16 pairs, no backpressure
        p0         = pops;
        out_ready  = 1'b1;
        stream_chk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(4'($urandom), 4'($urandom), 4'(i));
        end
        stream_chk = 1'b0;
        drain();
        check("stream_count", pops - p0, 16);

        // Stall: out_ready low for 4 cycles with in_valid held
        acc       = 0;
        out_ready = 1'b0;
        a         = 4'($urandom);
        b         = 4'($urandom);
        in_tag    = 4'($urandom);
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bit took;
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            if (k == 3) check("stall_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            if (took) begin
                a      = 4'($urandom);
                b      = 4'($urandom);
                in_tag = 4'($urandom);
            end
        end
        in_valid = 1'b0;
        check("stall_accepts", acc, 2);
        p0 = pops;
        drain();
        check("stall_release_count", pops - p0, 2);

        // Mixed random traffic with random backpressure
        p0         = pops;
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(4'($urandom), 4'($urandom), 4'($urandom));
        end
        rand_ready = 1'b0;
        drain();
        check("random_count", pops - p0, 150);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(4'd11, 4'd13, 4'd7);
        send(4'd9, 4'd6, 4'd8);
        @(negedge clk);
        check("full_before_rst", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 0);
        check("async_row_s", 32'(row_s), 0);
        check("async_row_c", 32'(row_c), 0);
        check("async_out_tag", 32'(out_tag), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        for (int k = 0; k < 4; k++) begin
            check("no_stale_out", 32'(out_valid), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        run_one(4'd3, 4'd5, 4'd4, ref_prod(4'd3, 4'd5), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
